// File: rtl/branch_checkpoint_allocator_if.sv
// Decode-side handshake for branch checkpoint allocation and commit.
// Master is decode/commit; slave is the allocator.
interface branch_checkpoint_allocator_if #(
  parameter int TAG_W = 2
);
  logic             alloc_valid;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             commit_valid;
  logic             bco_valid;

  modport master (
    output alloc_valid,
    output commit_valid,
    output bco_valid,
    input  alloc_ready,
    input  alloc_tag
  );

  modport slave (
    input  alloc_valid,
    input  commit_valid,
    input  bco_valid,
    output alloc_ready,
    output alloc_tag
  );
endinterface

// File: rtl/branch_checkpoint_allocator.sv
// In-order branch checkpoint tag ring with commit, BCO and snoop recovery.
// CHECKPOINT_ALLOC_BYPASS_EN: a full ring may regrant the tag committed that cycle.
module branch_checkpoint_allocator #(
  parameter int TAG_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    snoop_hit,
  branch_checkpoint_allocator_if.slave alloc_if,
  output logic                    cp_wea,
  output logic [TAG_W-1:0]        cp_addra,
  output logic                    cp_web,
  output logic [TAG_W-1:0]        cp_addrb,
  output logic                    cp_wec,
  output logic [TAG_W-1:0]        cp_addrc,
  output logic [(1<<TAG_W)-1:0]   cp_busy,
  output logic [TAG_W:0]          cp_count,
  output logic                    err_underflow
);
  localparam int DEPTH = 1 << TAG_W;
  localparam int CW    = TAG_W + 1;

  logic [TAG_W-1:0] head, tail, head_n, tail_n;
  logic [CW-1:0]    count, count_n;
  logic [DEPTH-1:0] busy, busy_n;
  logic             err;

  logic empty, full;
  logic commit_ok, bco_ok, grant, ready, underflow;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign commit_ok = alloc_if.commit_valid & ~alloc_if.bco_valid
                   & ~snoop_hit & ~empty;
  assign bco_ok    = alloc_if.bco_valid & ~snoop_hit & ~empty;
  assign underflow = (alloc_if.commit_valid | alloc_if.bco_valid)
                   & ~snoop_hit & empty;

`ifdef CHECKPOINT_ALLOC_BYPASS_EN
  // A full ring reuses the head slot being retired this cycle.
  assign ready = ~snoop_hit & ~alloc_if.bco_valid
               & (~full | commit_ok);
`else
  assign ready = ~full & ~snoop_hit & ~alloc_if.bco_valid;
`endif

  assign grant = alloc_if.alloc_valid & ready;

  assign alloc_if.alloc_ready = ready;
  assign alloc_if.alloc_tag   = tail;

  assign cp_wea   = grant;
  assign cp_addra = tail;
  assign cp_web   = bco_ok & ~reset;
  assign cp_addrb = head;
  assign cp_wec   = commit_ok & ~reset;
  assign cp_addrc = head;

  assign cp_busy       = busy;
  assign cp_count      = count;
  assign err_underflow = err;

  always_comb begin
    head_n  = head;
    tail_n  = tail;
    count_n = count;
    busy_n  = busy;
    unique case (1'b1)
      snoop_hit: begin
        tail_n  = head;
        busy_n  = '0;
        count_n = '0;
      end
      bco_ok: begin
        head_n  = head + 1'b1;
        tail_n  = head + 1'b1;
        busy_n  = '0;
        count_n = '0;
      end
      default: begin
        if (commit_ok) begin
          busy_n[head] = 1'b0;
          head_n       = head + 1'b1;
        end
        // Set after clear so a bypass regrant leaves the entry valid.
        if (grant) begin
          busy_n[tail] = 1'b1;
          tail_n       = tail + 1'b1;
        end
        count_n = count + CW'(grant) - CW'(commit_ok);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      err   <= 1'b0;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
      busy  <= busy_n;
      err   <= err | underflow;
    end
  end
endmodule

// File: tb/tb_branch_checkpoint_allocator.sv
// Random and directed check of the checkpoint allocator against a tag-queue model.
// Build with CHECKPOINT_ALLOC_BYPASS_EN to exercise the full-ring regrant.
module tb_branch_checkpoint_allocator;
  localparam int TAG_W = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic snoop_hit;
  logic cp_wea, cp_web, cp_wec;
  logic [TAG_W-1:0] cp_addra, cp_addrb, cp_addrc;
  logic [DEPTH-1:0] cp_busy;
  logic [TAG_W:0] cp_count;
  logic err_underflow;

  branch_checkpoint_allocator_if #(.TAG_W(TAG_W)) bif ();

  branch_checkpoint_allocator #(.TAG_W(TAG_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .snoop_hit    (snoop_hit),
    .alloc_if     (bif.slave),
    .cp_wea       (cp_wea),
    .cp_addra     (cp_addra),
    .cp_web       (cp_web),
    .cp_addrb     (cp_addrb),
    .cp_wec       (cp_wec),
    .cp_addrc     (cp_addrc),
    .cp_busy      (cp_busy),
    .cp_count     (cp_count),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: in-flight tags in age order, plus the oldest-pointer.
  int q[$];
  int m_head = 0;
  bit m_err  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    snoop_hit = 1'b0;
    bif.alloc_valid = 1'b0;
    bif.commit_valid = 1'b0;
    bif.bco_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_head = 0;
    m_err = 0;
  endtask

  task automatic step(input bit va, input bit cv, input bit bv, input bit sh);
    int size, tail, busy;
    bit empty, full, c_ok, b_ok, rdy, gnt;
    bif.alloc_valid = va;
    bif.commit_valid = cv;
    bif.bco_valid = bv;
    snoop_hit = sh;
    @(negedge clk);
    size = q.size();
    empty = (size == 0);
    full = (size == DEPTH);
    c_ok = cv && !bv && !sh && !empty;
    b_ok = bv && !sh && !empty;
    rdy = !full && !sh && !bv;
`ifdef CHECKPOINT_ALLOC_BYPASS_EN
    if (full && c_ok) rdy = 1;
`endif
    gnt = va && rdy;
    tail = (m_head + size) % DEPTH;
    busy = 0;
    foreach (q[i]) busy |= (1 << q[i]);
    chk("alloc_ready", int'(bif.alloc_ready), int'(rdy));
    chk("alloc_tag", int'(bif.alloc_tag), tail);
    chk("cp_wea", int'(cp_wea), int'(gnt));
    if (gnt) chk("cp_addra", int'(cp_addra), tail);
    chk("cp_web", int'(cp_web), int'(b_ok));
    if (b_ok) chk("cp_addrb", int'(cp_addrb), m_head);
    chk("cp_wec", int'(cp_wec), int'(c_ok));
    if (c_ok) chk("cp_addrc", int'(cp_addrc), m_head);
    chk("cp_busy", int'(cp_busy), busy);
    chk("cp_count", int'(cp_count), size);
    chk("err_underflow", int'(err_underflow), int'(m_err));
    @(posedge clk);
    if ((cv || bv) && empty && !sh) m_err = 1;
    if (sh) begin
      q.delete();
    end else if (b_ok) begin
      m_head = (m_head + 1) % DEPTH;
      q.delete();
    end else begin
      if (c_ok) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % DEPTH;
      end
      if (gnt) q.push_back(tail);
    end
    #1;
  endtask

  initial begin
    do_reset();
    // Reset state and four back-to-back grants, then a refused fifth.
    repeat (5) step(1, 0, 0, 0);
    chk("full_count", int'(cp_count), 4);
    // Commit twice from full, then regrant tag 0.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    // Tags 2,3,0 in flight: BCO recovers from head 2.
    step(0, 0, 1, 0);
    chk("post_bco_count", int'(cp_count), 0);
    step(1, 0, 0, 0);
    // Three in flight then snoop.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    step(1, 0, 0, 0);
    // Underflow sticks until reset.
    do_reset();
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("err_held", int'(err_underflow), 1);
    do_reset();
    step(0, 0, 0, 0);
    // Full plus commit plus alloc.
    repeat (4) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 31) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
